cache_fill_arbiter: RTL and testbench

- Parametrised miss-handling engine for the cached generation of the single-cycle core.
- Arbitrates block-fill requests from NUM_CH caches (ch0 = D-cache, ch1 = I-cache by default) onto one pipelined main memory.
- Issues BLOCK_WORDS consecutive word reads per miss and streams the returned words into the winning cache's data array.
- Replaces the core's direct single-word instruction and data memory path.

---
 rtl/cache_fill_arbiter.sv | 124 ++++++++++++
 tb/tb_cache_fill_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_arbiter.sv
// Block-fill miss engine: arbitrates NUM_CH cache fill requests onto one
// pipelined main memory, issues BLOCK_WORDS word reads per miss and streams
// returned words back into the granted cache's data array.
module cache_fill_arbiter #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int NUM_CH      = 2,
  parameter int ARB_MODE    = 0,
  localparam int CH_W       = $clog2(NUM_CH),
  localparam int IDX_W      = $clog2(BLOCK_WORDS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        miss_req,
  input  logic [NUM_CH*ADDR_W-1:0] miss_addr,
  output logic                     mem_rd,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     mem_valid,
  output logic                     fill_we,
  output logic [CH_W-1:0]          fill_ch,
  output logic [IDX_W-1:0]         fill_idx,
  output logic [DATA_W-1:0]        fill_data,
  output logic [NUM_CH-1:0]        fill_done,
  output logic                     busy
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF   = $clog2(BLOCK_WORDS * BYTES);
  localparam logic [ADDR_W-1:0] ALIGN = {ADDR_W{1'b1}} << OFF;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t              state;
  logic [CH_W-1:0]     grant_ch;
  logic [CH_W-1:0]     ptr;
  logic [CH_W-1:0]     pick;
  logic                pick_vld;
  logic [ADDR_W-1:0]   req_addr;
  // Counts reads already committed to the mem_rd register, so it runs one
  // ahead of the read actually on the bus.
  logic [IDX_W:0]      issue_cnt;
  logic [IDX_W-1:0]    ret_cnt;

  // Arbiter: cyclic search from ptr (round-robin) or from 0 (fixed priority).
  always_comb begin
    int j;
    pick     = '0;
    pick_vld = 1'b0;
    j        = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = ((ARB_MODE == 1) ? int'(ptr) : 0) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!pick_vld && miss_req[j]) begin
        pick     = CH_W'(j);
        pick_vld = 1'b1;
      end
    end
  end

  assign req_addr = miss_addr[int'(pick)*ADDR_W +: ADDR_W];

  // Fill stream is a straight pass-through of the memory return while filling.
  assign fill_we   = (state == FILL) && mem_valid;
  assign fill_ch   = fill_we ? grant_ch : '0;
  assign fill_idx  = fill_we ? ret_cnt  : '0;
  assign fill_data = fill_we ? mem_data : '0;

  // Main FSM: grant, issue reads, count returns, pulse fill_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_ch  <= '0;
      ptr       <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      fill_done <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state     <= FILL;
            grant_ch  <= pick;
            busy      <= 1'b1;
            ret_cnt   <= '0;
            issue_cnt <= (IDX_W+1)'(1);
            mem_rd    <= 1'b1;
            mem_addr  <= req_addr & ALIGN;
            if (ARB_MODE == 1)
              ptr <= (pick == CH_W'(NUM_CH-1)) ? '0 : pick + 1'b1;
          end
        end
        FILL: begin
          if (issue_cnt < (IDX_W+1)'(BLOCK_WORDS)) begin
            mem_rd    <= 1'b1;
            mem_addr  <= mem_addr + ADDR_W'(BYTES);
            issue_cnt <= issue_cnt + 1'b1;
          end else begin
            mem_rd <= 1'b0;
          end
          if (mem_valid) begin
            ret_cnt <= ret_cnt + 1'b1;
            if (ret_cnt == IDX_W'(BLOCK_WORDS-1)) begin
              state     <= DONE;
              fill_done <= NUM_CH'(1) << grant_ch;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          mem_rd    <= 1'b0;
          fill_done <= '0;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: two instances (default 2-ch fixed-priority,
// and 3-ch round-robin with 32-bit words / 4-word blocks), an in-order memory
// with programmable latency/stalls, and a transaction-level reference model.
module tb_cache_fill_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  req   [2];
  logic [15:0] maddr [2][4];
  logic        mv    [2];
  logic [31:0] md    [2];

  logic a_rd, a_we, a_busy; logic [15:0] a_addr, a_data;
  logic [0:0] a_ch; logic [2:0] a_idx; logic [1:0] a_done;
  logic b_rd, b_we, b_busy; logic [15:0] b_addr; logic [31:0] b_data;
  logic [1:0] b_ch; logic [1:0] b_idx; logic [2:0] b_done;

  cache_fill_arbiter #(.DATA_W(16), .ADDR_W(16), .BLOCK_WORDS(8), .NUM_CH(2), .ARB_MODE(0)) u_a (
    .clk(clk), .rst(rst), .miss_req(req[0][1:0]), .miss_addr({maddr[0][1], maddr[0][0]}),
    .mem_rd(a_rd), .mem_addr(a_addr), .mem_data(md[0][15:0]), .mem_valid(mv[0]),
    .fill_we(a_we), .fill_ch(a_ch), .fill_idx(a_idx), .fill_data(a_data),
    .fill_done(a_done), .busy(a_busy));

  cache_fill_arbiter #(.DATA_W(32), .ADDR_W(16), .BLOCK_WORDS(4), .NUM_CH(3), .ARB_MODE(1)) u_b (
    .clk(clk), .rst(rst), .miss_req(req[1][2:0]),
    .miss_addr({maddr[1][2], maddr[1][1], maddr[1][0]}),
    .mem_rd(b_rd), .mem_addr(b_addr), .mem_data(md[1]), .mem_valid(mv[1]),
    .fill_we(b_we), .fill_ch(b_ch), .fill_idx(b_idx), .fill_data(b_data),
    .fill_done(b_done), .busy(b_busy));

  int NCH [2] = '{2, 3};
  int BW  [2] = '{8, 4};
  int BYT [2] = '{2, 4};
  int ARB [2] = '{0, 1};

  int checks = 0, errors = 0, cyc = 0;

  // memory: in-order return queue per instance
  typedef struct { logic [15:0] a; int due; } rd_t;
  rd_t q0[$], q1[$];
  int  lat [2] = '{4, 4};
  bit  stall [2] = '{0, 0};
  bit  stray [2] = '{0, 0};
  bit  autoclr [2] = '{1, 1};

  // sampled outputs
  logic       o_rd [2], o_we [2], o_busy [2];
  logic [15:0] o_addr [2];
  logic [7:0] o_ch [2], o_idx [2];
  logic [31:0] o_data [2];
  logic [3:0] o_done [2];

  // reference model state (transaction level)
  bit m_act [2], m_dc [2];
  int m_ch [2], m_iss [2], m_ret [2], m_ptr [2];
  logic [15:0] m_base [2];

  // event logs
  int we_cnt [2], done_n [2], done_cyc [2];
  bit prev_rd [2];
  int dch0[$], dcyc0[$], rdst0[$], dch1[$];
  logic [15:0] alog1[$];
  int ilog1[$];

  typedef struct { bit rd; logic [15:0] addr; bit we; int idx; logic [1:0] done; bit busy; } vec_t;
  vec_t tbl [15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_fn(input int d, input logic [15:0] a);
    logic [31:0] x;
    x = ({16'h0, a} * 32'h9E37_79B1) ^ 32'hC0DE_5EED;
    return (d == 0) ? (x & 32'h0000_FFFF) : x;
  endfunction

  function automatic int pick(input int d);
    int s, j;
    s = (ARB[d] == 1) ? m_ptr[d] : 0;
    for (int k = 0; k < NCH[d]; k++) begin
      j = (s + k) % NCH[d];
      if (req[d][j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_dc[d] = 0; m_ch[d] = 0; m_iss[d] = 0; m_ret[d] = 0; m_ptr[d] = 0; m_base[d] = 0;
    end
    q0.delete(); q1.delete();
  endtask

  task automatic drive_mem(input int d);
    rd_t h;
    bit  have;
    mv[d] = 1'b0; md[d] = '0;
    have = (d == 0) ? (q0.size() > 0 && q0[0].due <= cyc) : (q1.size() > 0 && q1[0].due <= cyc);
    if (!stall[d] && have) begin
      h = (d == 0) ? q0.pop_front() : q1.pop_front();
      mv[d] = 1'b1; md[d] = mem_fn(d, h.a);
    end else if (stray[d] && !m_act[d]) begin
      mv[d] = 1'b1; md[d] = (d == 0) ? ($urandom & 32'hFFFF) : $urandom;
    end
  endtask

  task automatic gather();
    o_rd[0] = a_rd; o_addr[0] = a_addr; o_we[0] = a_we; o_ch[0] = 8'(a_ch); o_idx[0] = 8'(a_idx);
    o_data[0] = 32'(a_data); o_done[0] = 4'(a_done); o_busy[0] = a_busy;
    o_rd[1] = b_rd; o_addr[1] = b_addr; o_we[1] = b_we; o_ch[1] = 8'(b_ch); o_idx[1] = 8'(b_idx);
    o_data[1] = b_data; o_done[1] = 4'(b_done); o_busy[1] = b_busy;
  endtask

  task automatic model_step(input int d);
    bit e_rd, e_we; int e_ch, e_idx, g; logic [31:0] e_data; logic [3:0] e_done; logic [15:0] e_addr, a;
    rd_t r;
    e_rd   = m_act[d] && !m_dc[d] && (m_iss[d] < BW[d]);
    e_addr = m_base[d] + 16'(m_iss[d] * BYT[d]);
    e_we   = m_act[d] && !m_dc[d] && mv[d];
    e_ch   = e_we ? m_ch[d] : 0;
    e_idx  = e_we ? m_ret[d] : 0;
    a      = m_base[d] + 16'(m_ret[d] * BYT[d]);
    e_data = e_we ? mem_fn(d, a) : 32'h0;
    e_done = m_dc[d] ? 4'(1 << m_ch[d]) : 4'h0;
    chk($sformatf("model%0d_outputs", d),
        {o_rd[d], o_we[d], o_ch[d], o_idx[d], o_data[d], o_done[d], o_busy[d]},
        {e_rd, e_we, 8'(e_ch), 8'(e_idx), e_data, e_done, m_act[d]});
    if (e_rd) chk($sformatf("model%0d_mem_addr", d), 64'(o_addr[d]), 64'(e_addr));
    if (!m_act[d]) begin
      g = pick(d);
      if (g >= 0) begin
        m_act[d] = 1; m_dc[d] = 0; m_ch[d] = g; m_iss[d] = 0; m_ret[d] = 0;
        m_base[d] = maddr[d][g] - 16'(int'(maddr[d][g]) % (BW[d] * BYT[d]));
        if (ARB[d] == 1) m_ptr[d] = (g + 1) % NCH[d];
      end
    end else if (m_dc[d]) begin
      m_act[d] = 0; m_dc[d] = 0;
    end else begin
      if (e_rd) m_iss[d]++;
      if (e_we) begin m_ret[d]++; if (m_ret[d] == BW[d]) m_dc[d] = 1; end
    end
    if (o_rd[d] === 1'b1) begin
      r.a = o_addr[d]; r.due = cyc + lat[d];
      if (d == 0) q0.push_back(r); else q1.push_back(r);
    end
  endtask

  task automatic log_events(input int d);
    int ch;
    if (o_we[d] === 1'b1) begin
      we_cnt[d]++;
      if (d == 1) ilog1.push_back(int'(o_idx[1]));
    end
    if (d == 1 && o_rd[1] === 1'b1) alog1.push_back(o_addr[1]);
    if (d == 0 && o_rd[0] === 1'b1 && !prev_rd[0]) rdst0.push_back(cyc);
    prev_rd[d] = (o_rd[d] === 1'b1);
    if (o_done[d] != 0) begin
      ch = 0;
      for (int i = 0; i < 4; i++) if (o_done[d][i]) ch = i;
      done_n[d]++; done_cyc[d] = cyc;
      if (d == 0) begin dch0.push_back(ch); dcyc0.push_back(cyc); end
      else dch1.push_back(ch);
      if (autoclr[d]) req[d] = req[d] & ~o_done[d];
    end
  endtask

  // one clock cycle: drive memory, sample at negedge, check model, advance
  task automatic tick();
    for (int d = 0; d < 2; d++) drive_mem(d);
    #4;
    gather();
    for (int d = 0; d < 2; d++) begin model_step(d); log_events(d); end
    if (rst) model_reset();
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int d, input int maxc, input string nm);
    int n0;
    n0 = done_n[d];
    for (int i = 0; i < maxc && done_n[d] == n0; i++) tick();
    chk(nm, 64'(done_n[d] - n0), 64'd1);
  endtask

  initial begin
    int t0, w0;
    for (int d = 0; d < 2; d++) begin
      req[d] = '0; mv[d] = 1'b0; md[d] = '0;
      we_cnt[d] = 0; done_n[d] = 0; done_cyc[d] = 0; prev_rd[d] = 0;
      for (int c = 0; c < 4; c++) maddr[d][c] = '0;
    end
    model_reset();
    for (int c = 0; c < 15; c++) begin
      tbl[c].rd   = (c >= 1 && c <= 8);
      tbl[c].addr = 16'h1230 + 16'(2 * (c - 1));
      tbl[c].we   = (c >= 5 && c <= 12);
      tbl[c].idx  = c - 5;
      tbl[c].done = (c == 13) ? 2'b10 : 2'b00;
      tbl[c].busy = (c >= 1 && c <= 13);
    end

    // reset
    rst = 1'b1;
    @(posedge clk); #1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_a_outputs", {o_rd[0], o_addr[0], o_we[0], o_ch[0], o_idx[0], o_data[0], o_done[0], o_busy[0]}, 64'h0);
    chk("reset_b_outputs", {o_rd[1], o_addr[1], o_we[1], o_ch[1], o_idx[1], o_data[1], o_done[1], o_busy[1]}, 64'h0);

    // single fill on ch1, latency 4, table of expected per-cycle outputs
    lat[0] = 4; maddr[0][1] = 16'h1236; req[0] = 4'b0010;
    for (int c = 0; c < 15; c++) begin
      tick();
      chk($sformatf("tbl_c%0d_ctrl", c), {o_rd[0], o_we[0], o_done[0], o_busy[0]},
          {tbl[c].rd, tbl[c].we, 2'b00, tbl[c].done, tbl[c].busy});
      if (tbl[c].rd) chk($sformatf("tbl_c%0d_addr", c), 64'(o_addr[0]), 64'(tbl[c].addr));
      if (tbl[c].we) chk($sformatf("tbl_c%0d_idx_ch", c), {o_idx[0], o_ch[0]}, {8'(tbl[c].idx), 8'd1});
    end

    // fixed priority: both channels request together
    dch0.delete(); dcyc0.delete(); rdst0.delete();
    lat[0] = 2; maddr[0][0] = 16'h0400; maddr[0][1] = 16'h0812; req[0] = 4'b0011;
    for (int i = 0; i < 100 && dch0.size() < 2; i++) tick();
    chk("prio_done_count", 64'(dch0.size()), 64'd2);
    if (dch0.size() >= 2 && rdst0.size() >= 2) begin
      chk("prio_first_ch0", 64'(dch0[0]), 64'd0);
      chk("prio_second_ch1", 64'(dch0[1]), 64'd1);
      chk("prio_ch1_grant_after_done", 64'(rdst0[1]), 64'(dcyc0[0] + 2));
    end
    tick(); tick();

    // memory stall of 3 cycles after the 2nd return
    lat[0] = 4; maddr[0][0] = 16'h4000; req[0] = 4'b0001; we_cnt[0] = 0; t0 = cyc;
    for (int i = 0; i < 40 && we_cnt[0] < 2; i++) tick();
    stall[0] = 1;
    for (int i = 0; i < 3; i++) begin tick(); chk("stall_no_we", 64'(o_we[0]), 64'd0); end
    stall[0] = 0;
    wait_done(0, 40, "stall_done_seen");
    chk("stall_done_delay", 64'(done_cyc[0] - t0), 64'd16);
    tick();
    stray[0] = 1;
    for (int i = 0; i < 2; i++) begin tick(); chk("stray_idle_no_we", 64'(o_we[0]), 64'd0); end
    stray[0] = 0;

    // reset after the 3rd return
    lat[0] = 3; maddr[0][0] = 16'h2468; req[0] = 4'b0001; we_cnt[0] = 0;
    for (int i = 0; i < 40 && we_cnt[0] < 3; i++) tick();
    rst = 1'b1; req[0] = 4'b0000;
    tick();
    rst = 1'b0;
    tick();
    chk("post_reset_a_zero", {o_rd[0], o_addr[0], o_we[0], o_ch[0], o_idx[0], o_data[0], o_done[0], o_busy[0]}, 64'h0);
    w0 = done_n[0];
    for (int i = 0; i < 15; i++) tick();
    chk("post_reset_no_done", 64'(done_n[0] - w0), 64'd0);
    maddr[0][0] = 16'h0A1C; req[0] = 4'b0001; we_cnt[0] = 0;
    wait_done(0, 60, "refill_done_seen");
    chk("refill_word_count", 64'(we_cnt[0]), 64'd8);

    // 32-bit words, 4-word blocks
    alog1.delete(); ilog1.delete();
    lat[1] = 2; maddr[1][0] = 16'h00FF; req[1] = 4'b0001;
    wait_done(1, 40, "param_done_seen");
    chk("param_addr_count", 64'(alog1.size()), 64'd4);
    chk("param_idx_count", 64'(ilog1.size()), 64'd4);
    for (int i = 0; i < 4 && i < alog1.size() && i < ilog1.size(); i++) begin
      chk($sformatf("param_addr%0d", i), 64'(alog1[i]), 64'(16'h00F0 + 16'(4 * i)));
      chk($sformatf("param_idx%0d", i), 64'(ilog1[i]), 64'(i));
    end

    // round-robin, all three channels requesting continuously
    rst = 1'b1; tick(); rst = 1'b0; tick();
    dch1.delete(); autoclr[1] = 0; lat[1] = 3;
    maddr[1][0] = 16'h1000; maddr[1][1] = 16'h2004; maddr[1][2] = 16'h300C; req[1] = 4'b0111;
    for (int i = 0; i < 200 && dch1.size() < 6; i++) tick();
    req[1] = 4'b0000; autoclr[1] = 1;
    chk("rr_done_count", 64'(dch1.size()), 64'd6);
    for (int i = 0; i < 6 && i < dch1.size(); i++) chk($sformatf("rr_order%0d", i), 64'(dch1[i]), 64'(i % 3));
    for (int i = 0; i < 20; i++) tick();

    // randomized traffic against the reference model
    for (int n = 0; n < 4000; n++) begin
      if (n % 300 == 0) begin lat[0] = $urandom_range(1, 6); lat[1] = $urandom_range(1, 6); end
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < NCH[d]; c++) begin
          if ($urandom % 5 == 0) maddr[d][c] = 16'($urandom);
          if (!req[d][c] && $urandom % 6 == 0) req[d][c] = 1'b1;
        end
        stall[d] = ($urandom % 4 == 0);
        stray[d] = ($urandom % 3 == 0);
      end
      if ($urandom % 700 == 0) begin
        rst = 1'b1; req[0] = '0; req[1] = '0;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    stall[0] = 0; stall[1] = 0; stray[0] = 0; stray[1] = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
